// File: rtl/charbuf_port_ctrl.sv
// charbuf_port_ctrl: command slot, init-engine sequencer and write-port arbiter for the 80x32 character buffer
//   clk, reset                       clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_*        one-entry command slot (00 clear, 01 fill, 10 row tail erase)
//   wr_req/wr_addr/wr_data/wr_ack    CPU single-character write request and acknowledge
//   init_enable/init_row_only/init_sequential/init_row/init_col  engine start and mode
//   init_wr_en/init_addr/init_data   engine write strobe, address and data
//   buf_we/buf_addr/buf_data         registered buffer write port
//   busy/done/err                    status pulses
module charbuf_port_ctrl #(
  parameter int MAXCOL_M_1    = 79,
  parameter int START_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_row,
  input  logic [6:0]  cmd_col,
  input  logic        wr_req,
  input  logic [11:0] wr_addr,
  input  logic [6:0]  wr_data,
  output logic        wr_ack,
  output logic        init_enable,
  output logic        init_row_only,
  output logic        init_sequential,
  output logic [4:0]  init_row,
  output logic [6:0]  init_col,
  input  logic        init_wr_en,
  input  logic [11:0] init_addr,
  input  logic [6:0]  init_data,
  output logic        buf_we,
  output logic [11:0] buf_addr,
  output logic [6:0]  buf_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, START, WAIT_ACTIVE, RUN, DONE} state_t;
  state_t      state_q;
  logic        slot_full_q, cpu_turn_q, wr_ack_q, init_en_q, row_only_q, seq_q, buf_we_q, done_q, err_q;
  logic [1:0]  slot_op_q;
  logic [4:0]  slot_row_q, row_q;
  logic [6:0]  slot_col_q, col_q, buf_data_q;
  logic [11:0] buf_addr_q;
  logic [7:0]  to_cnt_q;
  logic        accept, reject, take, grant, go, engine_port;
  logic [1:0]  op_sel;
  logic [4:0]  row_sel;
  logic [6:0]  col_sel;
  always_comb begin
    accept = cmd_valid & ~slot_full_q;
    reject = accept & ((cmd_op == 2'b11) | ((cmd_op == 2'b10) & (int'(cmd_col) > MAXCOL_M_1)));
    take = accept & ~reject;
    // a CPU write owed after a command wins; otherwise any pending or arriving command goes first
    grant = (state_q == IDLE) & wr_req & ~wr_ack_q & (cpu_turn_q | ~(slot_full_q | take));
    go = (state_q == IDLE) & ~(cpu_turn_q & wr_req) & (slot_full_q | take);
    // an idle controller with an empty slot starts straight from the command inputs
    op_sel = slot_full_q ? slot_op_q : cmd_op;
    row_sel = slot_full_q ? slot_row_q : cmd_row;
    col_sel = slot_full_q ? slot_col_q : cmd_col;
    engine_port = (state_q == START) | (state_q == WAIT_ACTIVE) | (state_q == RUN);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      slot_full_q <= 1'b0;
      slot_op_q <= '0;
      slot_row_q <= '0;
      slot_col_q <= '0;
      cpu_turn_q <= 1'b0;
      wr_ack_q <= 1'b0;
      init_en_q <= 1'b1;
      row_only_q <= 1'b0;
      seq_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      buf_we_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      to_cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wr_ack_q <= grant;
      err_q <= reject;
      done_q <= 1'b0;
      init_en_q <= 1'b1;
      if (take & ~go) begin
        slot_full_q <= 1'b1;
        slot_op_q <= cmd_op;
        slot_row_q <= cmd_row;
        slot_col_q <= cmd_col;
      end else if (go) slot_full_q <= 1'b0;
      if (grant) cpu_turn_q <= 1'b0;
      // the CPU word is captured at the end of its ack cycle
      buf_we_q <= engine_port ? init_wr_en : wr_ack_q;
      if (engine_port | wr_ack_q) begin
        buf_addr_q <= engine_port ? init_addr : wr_addr;
        buf_data_q <= engine_port ? init_data : wr_data;
      end
      case (state_q)
        IDLE: if (go) begin
          state_q <= START;
          init_en_q <= 1'b0;
          row_only_q <= op_sel == 2'b10;
          seq_q <= op_sel == 2'b01;
          row_q <= row_sel;
          col_q <= col_sel;
        end
        START: begin
          state_q <= WAIT_ACTIVE;
          to_cnt_q <= '0;
        end
        WAIT_ACTIVE: if (init_wr_en) state_q <= RUN;
          else if (to_cnt_q == 8'(START_TIMEOUT - 1)) begin
            state_q <= IDLE;
            err_q <= 1'b1;
          end else to_cnt_q <= to_cnt_q + 8'd1;
        RUN: if (!init_wr_en) begin
          state_q <= DONE;
          done_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cpu_turn_q <= wr_req;
        end
      endcase
    end
  end
  assign cmd_ready = ~slot_full_q;
  assign wr_ack = wr_ack_q;
  assign init_enable = init_en_q;
  assign init_row_only = row_only_q;
  assign init_sequential = seq_q;
  assign init_row = row_q;
  assign init_col = col_q;
  assign buf_we = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign buf_data = buf_data_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_charbuf_port_ctrl.sv
// tb_charbuf_port_ctrl: self-checking bench with engine model, write scoreboard, vector table and random traffic
module tb_charbuf_port_ctrl;
  logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, wr_req = 1'b0, init_wr_en = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_row = '0;
  logic [6:0]  cmd_col = '0, wr_data = '0, init_data = '0;
  logic [11:0] wr_addr = '0, init_addr = '0;
  logic        cmd_ready, wr_ack, init_enable, init_row_only, init_sequential, buf_we, busy, done, err;
  logic [4:0]  init_row;
  logic [6:0]  init_col, buf_data;
  logic [11:0] buf_addr;
  charbuf_port_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .init_enable(init_enable), .init_row_only(init_row_only),
    .init_sequential(init_sequential), .init_row(init_row), .init_col(init_col),
    .init_wr_en(init_wr_en), .init_addr(init_addr), .init_data(init_data), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_data(buf_data), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] op;
    logic [4:0] row;
    logic [6:0] col;
    int         nwr;
    bit         bad;
  } vec_t;
  vec_t        tv[8];
  logic [18:0] eng_exp[$];
  logic [18:0] cpu_exp;
  bit          cpu_pend = 0, first_flag = 0, eng_stall = 0, eng_row = 0, eng_seq = 0;
  int          n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  int          n_done = 0, n_err = 0, n_start = 0, n_ack = 0, n_engwr = 0;
  int          first_we_cyc = 0, last_we_cyc = 0, done_cyc = 0, err_cyc = 0, ack_cyc = 0, start_cyc = 0;
  int          eng_left = 0;
  logic [11:0] eng_addr = '0;
  logic [6:0]  eng_data = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic bit is_bad(input logic [1:0] op, input logic [6:0] col);
    return op == 2'd3 || (op == 2'd2 && col > 7'd79);
  endfunction
  // expected engine traffic: address = col*32 + row, fill data = write index mod 128
  task automatic push_exp(input logic [1:0] op, input logic [4:0] row, input logic [6:0] col);
    if (op == 2'd2) for (int c = int'(col); c < 80; c++) eng_exp.push_back({12'(c * 32 + int'(row)), 7'd0});
    else for (int i = 0; i < 2560; i++) eng_exp.push_back({12'(i), (op == 2'd1) ? 7'(i % 128) : 7'd0});
  endtask
  // one cycle: check the write port, record pulses, answer acks, step the engine model
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cpu_pend) begin
      chk("cpu_we", 32'(buf_we), 32'd1);
      chk("cpu_write", 32'({buf_addr, buf_data}), 32'(cpu_exp));
      cpu_pend = 0;
    end else if (buf_we) begin
      chk("eng_expected", 32'(eng_exp.size() > 0), 32'd1);
      if (eng_exp.size() > 0) begin
        chk("eng_write", 32'({buf_addr, buf_data}), 32'(eng_exp.pop_front()));
        n_engwr++;
        if (first_flag) first_we_cyc = cyc;
        first_flag = 0;
        last_we_cyc = cyc;
      end
    end
    if (wr_ack) begin
      n_ack++;
      ack_cyc = cyc;
      cpu_exp = {wr_addr, wr_data};
      cpu_pend = 1;
      wr_req = 1'b0;
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (err) begin n_err++; err_cyc = cyc; end
    if (!init_enable) begin n_start++; start_cyc = cyc; end
    init_wr_en = 1'b0;
    if (eng_left > 0) begin
      init_wr_en = 1'b1;
      init_addr = eng_addr;
      init_data = eng_data;
      eng_left--;
      eng_addr = eng_addr + (eng_row ? 12'd32 : 12'd1);
      eng_data = eng_seq ? eng_data + 7'd1 : 7'd0;
    end
    if (!init_enable && !eng_stall) begin
      eng_row = init_row_only;
      eng_seq = init_sequential;
      eng_left = init_row_only ? 80 - int'(init_col) : 2560;
      eng_addr = init_row_only ? {init_col, init_row} : 12'd0;
      eng_data = 7'd0;
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [4:0] row, input logic [6:0] col, input bit push);
    int k = 0;
    while (!cmd_ready && k < 6000) begin tick(); k++; end
    if (k >= 6000) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_row = row;
    cmd_col = col;
    acc_cyc = cyc;
    first_flag = 1;
    if (push && !is_bad(op, col)) push_exp(op, row, col);
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic wait_quiet();
    int k = 0;
    while ((busy || wr_req || !cmd_ready || eng_left > 0 || cpu_pend) && k < 8000) begin tick(); k++; end
    chk("quiet_timeout", 32'(k < 8000), 32'd1);
    repeat (3) tick();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int d0, e0, s0, w0, a0, nd, ne, na;
    logic [1:0] op;
    logic [4:0] row;
    logic [6:0] col;
    tv[0] = '{2'd0, 5'd0, 7'd0, 2560, 1'b0};
    tv[1] = '{2'd1, 5'd0, 7'd0, 2560, 1'b0};
    tv[2] = '{2'd2, 5'd5, 7'd70, 10, 1'b0};
    tv[3] = '{2'd2, 5'd31, 7'd0, 80, 1'b0};
    tv[4] = '{2'd2, 5'd0, 7'd79, 1, 1'b0};
    tv[5] = '{2'd2, 5'd3, 7'd80, 0, 1'b1};
    tv[6] = '{2'd2, 5'd5, 7'd90, 0, 1'b1};
    tv[7] = '{2'd3, 5'd0, 7'd0, 0, 1'b1};
    tick();
    tick();
    chk("reset_flags", 32'({cmd_ready, init_enable, buf_we, busy, done, err, wr_ack, init_row_only, init_sequential}), 32'h180);
    chk("reset_pos", 32'({init_row, init_col}), 32'd0);
    chk("reset_buf", 32'({buf_addr, buf_data}), 32'd0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      d0 = n_done; e0 = n_err; s0 = n_start; w0 = n_engwr;
      issue(tv[i].op, tv[i].row, tv[i].col, 1);
      if (tv[i].bad) chk("reject_ready", 32'(cmd_ready), 32'd1);
      wait_quiet();
      chk("vec_writes", 32'(n_engwr - w0), 32'(tv[i].nwr));
      chk("vec_done", 32'(n_done - d0), 32'(!tv[i].bad));
      chk("vec_err", 32'(n_err - e0), 32'(tv[i].bad));
      chk("vec_start", 32'(n_start - s0), 32'(!tv[i].bad));
      if (tv[i].bad) chk("err_latency", 32'(err_cyc - acc_cyc), 32'd1);
      else begin
        chk("start_latency", 32'(start_cyc - acc_cyc), 32'd1);
        chk("first_write_latency", 32'(first_we_cyc - acc_cyc), 32'd3);
        chk("done_latency", 32'(done_cyc - last_we_cyc), 32'd1);
      end
    end
    a0 = n_ack; d0 = n_done;
    issue(2'd0, 5'd0, 7'd0, 1);
    repeat (20) tick();
    wr_req = 1'b1; wr_addr = 12'h123; wr_data = 7'h41;
    issue(2'd2, 5'd1, 7'd60, 1);
    chk("queued_not_ready", 32'(cmd_ready), 32'd0);
    wait_quiet();
    chk("fair_acks", 32'(n_ack - a0), 32'd1);
    chk("fair_done", 32'(n_done - d0), 32'd2);
    chk("fair_ack_before_start", 32'(ack_cyc < start_cyc), 32'd1);
    a0 = n_ack;
    wr_req = 1'b1; wr_addr = 12'h7ff; wr_data = 7'h15;
    issue(2'd2, 5'd2, 7'd78, 1);
    chk("collide_start", 32'(init_enable), 32'd0);
    chk("collide_no_ack", 32'(wr_ack), 32'd0);
    wait_quiet();
    chk("collide_acks", 32'(n_ack - a0), 32'd1);
    chk("collide_ack_after_done", 32'(ack_cyc > done_cyc), 32'd1);
    eng_stall = 1;
    e0 = n_err; d0 = n_done;
    issue(2'd0, 5'd0, 7'd0, 0);
    begin
      int k = 0;
      while (n_err == e0 && k < 20) begin tick(); k++; end
    end
    chk("timeout_latency", 32'(err_cyc - acc_cyc), 32'd6);
    chk("timeout_idle", 32'(busy), 32'd0);
    chk("timeout_no_done", 32'(n_done - d0), 32'd0);
    eng_stall = 0;
    wait_quiet();
    issue(2'd0, 5'd0, 7'd0, 1);
    repeat (30) tick();
    chk("pre_reset_we", 32'({buf_we, busy}), 32'd3);
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'({buf_we, busy, cmd_ready, init_enable}), 32'd3);
    eng_left = 0;
    init_wr_en = 1'b0;
    eng_exp.delete();
    cpu_pend = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    d0 = n_done; e0 = n_err; s0 = n_start; a0 = n_ack;
    nd = 0; ne = 0; na = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1 && !wr_req && !cpu_pend) begin
        wr_req = 1'b1;
        wr_addr = 12'($urandom);
        wr_data = 7'($urandom);
        na++;
      end
      if ($urandom_range(0, 2) == 0) begin
        op = 2'($urandom_range(2, 3));
        row = 5'($urandom);
        col = 7'($urandom_range(0, 95));
        if (is_bad(op, col)) ne++;
        else nd++;
        issue(op, row, col, 1);
      end
      repeat ($urandom_range(0, 4)) tick();
    end
    wait_quiet();
    chk("rand_done", 32'(n_done - d0), 32'(nd));
    chk("rand_err", 32'(n_err - e0), 32'(ne));
    chk("rand_start", 32'(n_start - s0), 32'(nd));
    chk("rand_acks", 32'(n_ack - a0), 32'(na));
    chk("queue_empty", 32'(eng_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/charbuf_port_ctrl.md
# charbuf_port_ctrl

Controller and write-port arbiter for the 80x32 character buffer. It accepts screen-maintenance commands (clear to NUL, fill with a sequential pattern, erase row tail) and sequences the buffer-initialisation engine through its start/complete handshake. It shares the single buffer write port between that engine's burst writes and single-character writes from the CPU/keyboard terminal path. It sits between the terminal command logic and the character-buffer RAM write port.

## Interface
Parameters:
- `MAXCOL_M_1`, 79: last valid column; a row-erase command with a larger column is rejected.
- `START_TIMEOUT`, 4: cycles allowed in WAIT_ACTIVE for `init_wr_en` to rise.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high; all state and outputs are cleared immediately.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command slot empty; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  command code: 00 = clear to NUL, 01 = sequential fill, 10 = erase row tail, 11 = reserved.
- `cmd_row`  in  5  row for op 10.
- `cmd_col`  in  7  start column for op 10.
- `wr_req`  in  1  CPU write request; held high until acknowledged.
- `wr_addr`  in  12  {col[6:0], row[4:0]}.
- `wr_data`  in  7  character code.
- `wr_ack`  out  1  one-cycle pulse; the write is captured in that cycle.
- `init_enable`  out  1  engine start; active-low pulse, idles at 1.
- `init_row_only`, `init_sequential`  out  1  engine mode.
- `init_row` (out, 5) and `init_col` (out, 7)  engine row-erase start position.
- `init_wr_en`  in  1  engine write strobe (busy indicator).
- `init_addr` (in, 12) and `init_data` (in, 7)  engine write address and data.
- `buf_we`  out  1  buffer write enable, registered.
- `buf_addr` (out, 12) and `buf_data` (out, 7)  buffer write address and data, registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse on a rejected command or a start timeout.

## Operation
- **Command slot:** one entry. `cmd_ready = ~slot_full`.
- **Rejected commands:** op 11, or op 10 with `cmd_col > MAXCOL_M_1`.
  - Accepted, but not stored.
  - `err` pulses in the cycle after acceptance.
- **State machine:** IDLE, START, WAIT_ACTIVE, RUN, DONE.
- **IDLE:**
  - Priority 1: `cpu_turn & wr_req` grants the CPU write.
  - Priority 2: otherwise, `slot_full` moves to START. Mode outputs are loaded from the slot and the slot is freed.
  - Priority 3: otherwise, `wr_req` grants the CPU write.
- **Mode outputs:** `init_row_only = (op==10)` and `init_sequential = (op==01)`. `init_row`/`init_col` are stable from START until the next START.
- **START:** `init_enable = 0` for exactly one cycle, then WAIT_ACTIVE.
- **WAIT_ACTIVE:**
  - `init_wr_en = 1` moves to RUN.
  - After `START_TIMEOUT` cycles without it: `err` pulse, then IDLE. The command is dropped.
- **RUN:** the port is owned by the engine. When `init_wr_en = 0`, move to DONE.
- **DONE:**
  - `done` pulses.
  - `cpu_turn <= wr_req`.
  - Next state is IDLE.
- `cpu_turn` clears when a CPU write is granted. This guarantees one CPU write between back-to-back commands.
- **CPU grant:**
  - `wr_ack = 1` for one cycle.
  - `wr_addr`/`wr_data` are registered onto `buf_*` with `buf_we = 1` in the next cycle.
  - At most one grant per two cycles: a grant cycle is followed by a `wr_ack = 0` cycle.
- **Port source:**
  - START through RUN: `buf_we`/`buf_addr`/`buf_data` <= `init_wr_en`/`init_addr`/`init_data`.
  - Otherwise: the CPU grant path.
  - CPU writes are never granted in START, WAIT_ACTIVE, RUN or DONE.
- **Reset values:**
  - State IDLE; slot empty; `cpu_turn` = 0.
  - `cmd_ready` = 1; `init_enable` = 1.
  - `init_row_only`, `init_sequential`, `init_row`, `init_col` = 0.
  - `buf_we`, `buf_addr`, `buf_data` = 0.
  - `wr_ack`, `busy`, `done`, `err` = 0.
- **Reset mid-command:** the pending command and the in-flight command are discarded. The engine is not reset by this block.

## Timing
- Command accepted at cycle T while IDLE with the slot empty:
  - T+1: START (`init_enable` = 0).
  - T+2: WAIT_ACTIVE, with `init_wr_en` seen high.
  - T+3: RUN.
  - The first engine write appears on `buf_*` at T+3.
- Full-screen commands: 2560 engine writes, so `buf_we` stays high for 2560 consecutive cycles.
- Row erase from column c: 80−c writes.
- `done` asserts 2 cycles after the last engine write is presented by the engine.
- A command arriving while busy is held in the slot and `cmd_ready` drops the next cycle.
- `cmd_valid` and `wr_req` in the same IDLE cycle with `cpu_turn` = 0: the command is captured and the write is stalled, because a START is pending.
- CPU write latency: `wr_ack` in the grant cycle, `buf_we` in the cycle after.

## Test plan
- **Clear to NUL:** reset, then op 00 → 2560 consecutive `buf_we` cycles, addresses in col-major order {0,0}…{79,31}, data 0; `done` exactly once.
- **Sequential fill:** op 01 → `buf_data` at address 0 = 0, at address 1 = 1, incrementing; the final write carries address 2559; `busy` falls after `done`.
- **Row erase:** op 10 with row=5, col=70 → 10 writes, addresses {70,5}…{79,5}, data 0.
- **Invalid commands:** op 10 with col=90, then op 11 → `err` pulses twice; no `init_enable` pulse; `cmd_ready` stays 1.
- **Fairness:** op 00, then `wr_req` (addr 0x123, data 0x41) held and a second op 10 queued → the CPU write gets `wr_ack` before the second START; `buf_data` = 0x41 one cycle after the ack.
- **Stalled engine and reset:**
  - Tie `init_wr_en` = 0 → `err` after 4 WAIT_ACTIVE cycles, then IDLE.
  - Assert `reset` during RUN → `buf_we`/`busy` drop to 0 immediately (asynchronously) and `cmd_ready` = 1.
